ft_nmr_controller: RTL

- Parametrised successor to the dual-core fault-tolerance module: supports DMR (2 cores) or TMR (3 cores) lockstep.
- Each cycle it compares the register-file write ports and commit PCs of all cores.
- It keeps a shadow register file of agreed writes.
- On any disagreement it halts all cores, restores GPRs and PC through the debug interface, then resumes.
- Sits in the SoC between the core regfile/debug ports and the SoC top.

---
 rtl/ft_nmr_pkg.sv | 28 ++
 rtl/ft_nmr_voter.sv | 52 +++++
 rtl/ft_nmr_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ft_nmr_pkg.sv
// Shared types and constants for the N-modular-redundancy lockstep controller.
package ft_nmr_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    HALT     = 3'd1,
    RESTORE  = 3'd2,
    WRITE_PC = 3'd3,
    RESUME   = 3'd4
  } state_t;

  localparam logic [14:0] DBG_GPR_BASE = 15'h400;
  localparam logic [14:0] DBG_NPC_ADDR = 15'h2000;
  localparam int          NUM_GPR      = 32;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] cpc;
  } tuple_t;

  // A core that is not writing compares as a bare {we=0}; address, data and PC are ignored.
  function automatic tuple_t cmp_view(input tuple_t t);
    cmp_view = t.we ? t : '0;
  endfunction

endpackage

// File: rtl/ft_nmr_voter.sv
// Combinational comparator/voter across the redundant cores' commit tuples.
// Only N_CORES of 2 (DMR) or 3 (TMR) is meaningful.
module ft_nmr_voter
  import ft_nmr_pkg::*;
#(
  parameter int N_CORES = 2
) (
  input  tuple_t [N_CORES-1:0] i_tup,
  output logic                 o_agree,
  output tuple_t               o_major,
  output logic [N_CORES-1:0]   o_faulty,
  output logic                 o_no_major
);

  logic w_e01;
  assign w_e01 = (cmp_view(i_tup[0]) == cmp_view(i_tup[1]));

  if (N_CORES == 3) begin : g_tmr
    logic w_e02;
    logic w_e12;
    assign w_e02 = (cmp_view(i_tup[0]) == cmp_view(i_tup[2]));
    assign w_e12 = (cmp_view(i_tup[1]) == cmp_view(i_tup[2]));

    // Majority vote; the raw tuple of a majority core is forwarded so its PC survives we=0.
    always_comb begin
      o_agree    = w_e01 & w_e02;
      o_major    = i_tup[0];
      o_faulty   = '0;
      o_no_major = 1'b0;
      if (w_e01 && !w_e02) begin
        o_faulty = 3'b100;
      end else if (w_e02 && !w_e01) begin
        o_faulty = 3'b010;
      end else if (w_e12 && !w_e01) begin
        o_faulty = 3'b001;
        o_major  = i_tup[1];
      end else if (!w_e01 && !w_e02 && !w_e12) begin
        o_faulty   = '1;
        o_no_major = 1'b1;
      end
    end
  end else begin : g_dmr
    // With two cores a difference cannot be attributed, so both are blamed.
    always_comb begin
      o_agree    = w_e01;
      o_major    = i_tup[0];
      o_faulty   = w_e01 ? '0 : '1;
      o_no_major = 1'b0;
    end
  end

endmodule

// File: rtl/ft_nmr_controller.sv
// Lockstep checker: compares core commits, keeps a shadow GPR file of agreed
// writes and replays it over the debug port after a disagreement.
// state    | meaning
// RUN      | cores running, commits compared each cycle
// HALT     | halt requested, waiting for all cores (or parked after fatal)
// RESTORE  | replaying shadow x1..x31 over debug port
// WRITE_PC | writing restore PC to the debug next-PC register
// RESUME   | one-cycle resume pulse
module ft_nmr_controller
  import ft_nmr_pkg::*;
#(
  parameter int N_CORES      = 2,
  parameter int HALT_TIMEOUT = 64,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [N_CORES-1:0]      we_i,
  input  logic [5*N_CORES-1:0]    waddr_i,
  input  logic [32*N_CORES-1:0]   wdata_i,
  input  logic [32*N_CORES-1:0]   cpc_i,
  input  logic [N_CORES-1:0]      halted_i,
  output logic                    halt_o,
  output logic                    resume_o,
  output logic                    dbg_we_o,
  output logic [14:0]             dbg_addr_o,
  output logic [31:0]             dbg_wdata_o,
  output logic                    error_o,
  output logic [N_CORES-1:0]      faulty_o,
  output logic                    fatal_o,
  output logic                    busy_o,
  output logic [ERR_CNT_W-1:0]    err_count_o
);

  localparam int          TMO_W    = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);
  localparam bit          IS_TMR   = (N_CORES == 3);

  state_t                 r_state, w_state_nxt;
  logic [31:0]            r_shadow [NUM_GPR];
  logic [4:0]             r_idx;
  logic [TMO_W-1:0]       r_tmo;
  logic [31:0]            r_rpc;
  logic [N_CORES-1:0]     r_faulty;
  logic                   r_fatal;
  logic                   r_park;
  logic                   r_error;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  tuple_t [N_CORES-1:0]   w_tup;
  logic                   w_agree, w_no_major, w_mismatch;
  tuple_t                 w_major;
  logic [N_CORES-1:0]     w_faulty;
  logic                   w_sh_we;
  logic [4:0]             w_sh_addr;
  logic [31:0]            w_sh_data;

  for (genvar k = 0; k < N_CORES; k++) begin : g_tup
    assign w_tup[k] = {we_i[k], waddr_i[5*k +: 5], wdata_i[32*k +: 32], cpc_i[32*k +: 32]};
  end

  ft_nmr_voter #(.N_CORES(N_CORES)) u_voter (
    .i_tup      (w_tup),
    .o_agree    (w_agree),
    .o_major    (w_major),
    .o_faulty   (w_faulty),
    .o_no_major (w_no_major)
  );

  assign w_mismatch = (r_state == RUN) && enable_i && !w_agree;

  // Next state and debug-port outputs decoded from the registered state.
  always_comb begin
    w_state_nxt = r_state;
    halt_o      = 1'b0;
    resume_o    = 1'b0;
    dbg_we_o    = 1'b0;
    dbg_addr_o  = '0;
    dbg_wdata_o = '0;
    case (r_state)
      RUN:      if (w_mismatch) w_state_nxt = HALT;
      HALT: begin
        halt_o = 1'b1;
        if (!r_park && (&halted_i)) w_state_nxt = RESTORE;
      end
      RESTORE: begin
        halt_o      = 1'b1;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = DBG_GPR_BASE + {8'd0, r_idx, 2'b00};
        dbg_wdata_o = r_shadow[r_idx];
        if (r_idx == 5'd31) w_state_nxt = WRITE_PC;
      end
      WRITE_PC: begin
        halt_o      = 1'b1;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = DBG_NPC_ADDR;
        dbg_wdata_o = r_rpc;
        w_state_nxt = RESUME;
      end
      RESUME: begin
        resume_o    = 1'b1;
        w_state_nxt = r_fatal ? HALT : RUN;
      end
      default:  w_state_nxt = RUN;
    endcase
  end

  // Shadow write selection: agreed or outvoted-majority commit when checking, core 0 otherwise.
  always_comb begin
    w_sh_we   = 1'b0;
    w_sh_addr = w_major.waddr;
    w_sh_data = w_major.wdata;
    if (r_state == RUN) begin
      if (!enable_i) begin
        w_sh_we   = w_tup[0].we && (w_tup[0].waddr != 5'd0);
        w_sh_addr = w_tup[0].waddr;
        w_sh_data = w_tup[0].wdata;
      end else if (w_agree || (IS_TMR && !w_no_major)) begin
        w_sh_we = w_major.we && (w_major.waddr != 5'd0);
      end
    end
  end

  // Shadow register file of committed GPR values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_GPR; i++) r_shadow[i] <= '0;
    end else if (w_sh_we) begin
      r_shadow[w_sh_addr] <= w_sh_data;
    end
  end

  // State register, recovery bookkeeping and halt timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= RUN;
      r_idx     <= 5'd1;
      r_tmo     <= '0;
      r_rpc     <= '0;
      r_faulty  <= '0;
      r_fatal   <= 1'b0;
      r_park    <= 1'b0;
      r_error   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_error <= 1'b0;
      if (w_mismatch) begin
        r_error  <= 1'b1;
        r_rpc    <= w_major.cpc;
        r_faulty <= w_faulty;
        if (w_no_major) r_fatal <= 1'b1;
        if (~&r_err_cnt) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
      if (r_state == HALT) begin
        if (!r_park && !(&halted_i)) begin
          if (r_tmo == TMO_LAST) begin
            r_fatal <= 1'b1;
            r_park  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
      end else begin
        r_tmo <= '0;
      end
      if (r_state == RESTORE) r_idx <= (r_idx == 5'd31) ? 5'd1 : r_idx + 5'd1;
      // A fatal recovery parks in HALT for good once the replay is done.
      if (r_state == RESUME && r_fatal) r_park <= 1'b1;
    end
  end

  assign error_o     = r_error;
  assign faulty_o    = r_faulty;
  assign fatal_o     = r_fatal;
  assign busy_o      = (r_state != RUN);
  assign err_count_o = r_err_cnt;

endmodule
